mmio_led_responder: RTL and testbench

//  Memory-mapped bus responder answering priRV32 data-bus loads/stores; owns the board led pins.
//  - Registers: LED output, write-1-set, write-1-clear, blink prescaler, blink mask.
//  - Single outstanding request; valid/ready on request and response channels.

---
 rtl/mmio_led_pkg.sv | 34 +++
 rtl/mmio_led_blink_prescaler.sv | 33 +++
 rtl/mmio_led_responder.sv | 188 ++++++++++++++++++
 tb/tb_mmio_led_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_led_pkg.sv
// Shared definitions for the LED bus responder: register offsets, the
// response FSM state type, the response payload and byte-strobe helpers.
package mmio_led_pkg;

    localparam logic [7:0] OFF_LED_OUT    = 8'h00;
    localparam logic [7:0] OFF_LED_SET    = 8'h04;
    localparam logic [7:0] OFF_LED_CLR    = 8'h08;
    localparam logic [7:0] OFF_BLINK_DIV  = 8'h0C;
    localparam logic [7:0] OFF_BLINK_MASK = 8'h10;
    localparam logic [7:0] OFF_TICKS      = 8'h14;

    typedef enum logic [0:0] {
        IDLE,
        RESP
    } resp_state_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    // Expand the four byte enables into a 32-bit bit mask.
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    // Replace only the masked bits of old_val with new_val.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/mmio_led_blink_prescaler.sv
// Blink prescaler: counts 0..div-1 and pulses tick on the terminal count.
// A divider of 0 behaves like 1 (tick every cycle). clr restarts the count.
// Only exists when MMIO_LED_BLINK_EN is defined, since nothing else uses it.
`ifdef MMIO_LED_BLINK_EN
module blink_prescaler
    import mmio_led_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] div,
    input  logic        clr,
    output logic        tick
);

    logic [31:0] count;
    logic [31:0] term;

    assign term = (div == 32'd0) ? 32'd0 : div - 32'd1;
    assign tick = (count == term);

    // Free-running count that wraps on tick and restarts on a divider store.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/mmio_led_responder.sv
// Memory-mapped responder for core data-bus loads and stores that owns the
// board LED pins. One request is in flight at a time; the response is held
// until the core takes it. Define MMIO_LED_BLINK_EN to build in the blink
// prescaler, BLINK_DIV, BLINK_MASK and TICKS; without it those offsets are
// unmapped and LED_OUT only changes through stores.
module mmio_led_responder
    import mmio_led_pkg::*;
#(
    parameter int          LED_W   = 8,
    parameter int          ADDR_W  = 5,
    parameter logic [31:0] DIV_RST = 32'd50
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [LED_W-1:0]  led
);

    resp_state_t       state;
    resp_t             rsp_d;
    logic              accept;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       wmask;
    logic [LED_W-1:0]  led_out;
    logic [LED_W-1:0]  led_store;
    logic [LED_W-1:0]  led_next;
    logic              addr_lsb_unused;

`ifdef MMIO_LED_BLINK_EN
    logic [31:0]       blink_div;
    logic [31:0]       div_store;
    logic [31:0]       ticks;
    logic [LED_W-1:0]  blink_mask;
    logic [LED_W-1:0]  mask_store;
    logic              div_wr;
    logic              tick;
`else
    logic [31:0]       div_rst_unused;
    assign div_rst_unused = DIV_RST;
`endif

    // Byte lanes inside a word are not decoded.
    assign word_addr       = {req_addr[ADDR_W-1:2], 2'b00};
    assign addr_lsb_unused = ^req_addr[1:0];
    assign wmask           = strb_to_mask(req_wstrb);
    assign accept          = (state == IDLE) && req_ready && req_valid;

    // Decode the presented request into its response and the register values it would leave behind.
    always_comb begin
        rsp_d     = '0;
        led_store = led_out;
`ifdef MMIO_LED_BLINK_EN
        div_store  = blink_div;
        mask_store = blink_mask;
        div_wr     = 1'b0;
`endif
        if (word_addr == ADDR_W'(OFF_LED_OUT)) begin
            if (req_we) begin
                led_store = LED_W'(merge_bytes(32'(led_out), req_wdata, wmask));
            end else begin
                rsp_d.rdata = 32'(led_out);
            end
        end else if (word_addr == ADDR_W'(OFF_LED_SET)) begin
            if (req_we) begin
                led_store = led_out | LED_W'(req_wdata & wmask);
            end
        end else if (word_addr == ADDR_W'(OFF_LED_CLR)) begin
            if (req_we) begin
                led_store = led_out & ~LED_W'(req_wdata & wmask);
            end
`ifdef MMIO_LED_BLINK_EN
        end else if (word_addr == ADDR_W'(OFF_BLINK_DIV)) begin
            if (req_we) begin
                div_store = merge_bytes(blink_div, req_wdata, wmask);
                div_wr    = |req_wstrb;
            end else begin
                rsp_d.rdata = blink_div;
            end
        end else if (word_addr == ADDR_W'(OFF_BLINK_MASK)) begin
            if (req_we) begin
                mask_store = LED_W'(merge_bytes(32'(blink_mask), req_wdata, wmask));
            end else begin
                rsp_d.rdata = 32'(blink_mask);
            end
        end else if (word_addr == ADDR_W'(OFF_TICKS)) begin
            if (req_we) begin
                rsp_d.err = 1'b1;
            end else begin
                rsp_d.rdata = ticks;
            end
`endif
        end else begin
            rsp_d.err = 1'b1;
        end
    end

    // A store lands first; a blink tick in the same cycle then toggles the stored value.
`ifdef MMIO_LED_BLINK_EN
    assign led_next = (accept ? led_store : led_out) ^ (tick ? blink_mask : {LED_W{1'b0}});
`else
    assign led_next = accept ? led_store : led_out;
`endif

    // Request/response handshake: accept in IDLE, hold the response in RESP until consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= RESP;
                        req_ready <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rsp_d.rdata;
                        rsp_err   <= rsp_d.err;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // LED register and the pin drive, which follows it one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_out <= '0;
            led     <= '0;
        end else begin
            led_out <= led_next;
            led     <= led_out;
        end
    end

`ifdef MMIO_LED_BLINK_EN
    // Blink configuration registers and the tick counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_div  <= DIV_RST;
            blink_mask <= '0;
            ticks      <= '0;
        end else begin
            if (accept) begin
                blink_div  <= div_store;
                blink_mask <= mask_store;
            end
            if (tick) begin
                ticks <= ticks + 32'd1;
            end
        end
    end

    blink_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .div   (blink_div),
        .clr   (accept && div_wr),
        .tick  (tick)
    );
`endif

endmodule

// File: tb/tb_mmio_led_responder.sv
// Self-checking bench for mmio_led_responder. A cycle-level reference model
// of the register map, handshake and blink behaviour predicts every output
// each clock; directed sequences cover the documented scenarios and a random
// phase follows. Works with or without MMIO_LED_BLINK_EN.
module tb_mmio_led_responder;

    localparam int          LED_W   = 8;
    localparam int          ADDR_W  = 5;
    localparam logic [31:0] DIV_RST = 32'd50;
    localparam logic [31:0] LED_ALL = 32'h0000_00FF;
`ifdef MMIO_LED_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [LED_W-1:0]  led;

    int testsRun    = 0;
    int testsFailed = 0;

    // reference model state
    logic [31:0] mLedOut, mMask, mDiv, mTicks, mPresc, mRdata;
    logic [7:0]  mLed;
    bit          mReady, mValid, mErr, mAccepted, mConsumed, mInReset;

    mmio_led_responder #(
        .LED_W   (LED_W),
        .ADDR_W  (ADDR_W),
        .DIV_RST (DIV_RST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .led       (led)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the reference model by one rising edge using the inputs present at that edge.
    function automatic void modelStep();
        logic [31:0] bm, newLed, newMask, newDiv, rd;
        bit          tickNow, divWritten, err;
        int          idx;
        if (reset) begin
            mLedOut = 0; mMask = 0; mDiv = DIV_RST; mTicks = 0; mPresc = 0;
            mLed = 0; mReady = 0; mValid = 0; mRdata = 0; mErr = 0;
            mAccepted = 0; mConsumed = 0; mInReset = 1;
            return;
        end
        mInReset   = 0;
        newLed     = mLedOut;
        newMask    = mMask;
        newDiv     = mDiv;
        divWritten = 0;
        tickNow    = BLINK_EN && (mPresc == ((mDiv == 0) ? 32'd0 : mDiv - 32'd1));
        mLed       = mLedOut[7:0];
        mAccepted  = req_valid && mReady;
        mConsumed  = 0;
        if (mAccepted) begin
            bm = 0;
            for (int b = 0; b < 4; b++) if (req_wstrb[b]) bm[8*b +: 8] = 8'hFF;
            idx = int'(req_addr) / 4;
            rd  = 0;
            err = 0;
            case (idx)
                0: if (req_we) newLed = ((mLedOut & ~bm) | (req_wdata & bm)) & LED_ALL;
                   else rd = mLedOut;
                1: if (req_we) newLed = mLedOut | (req_wdata & bm & LED_ALL);
                2: if (req_we) newLed = mLedOut & ~(req_wdata & bm);
                3: if (!BLINK_EN) err = 1;
                   else if (req_we) begin
                       newDiv = (mDiv & ~bm) | (req_wdata & bm);
                       divWritten = (req_wstrb != 0);
                   end else rd = mDiv;
                4: if (!BLINK_EN) err = 1;
                   else if (req_we) newMask = ((mMask & ~bm) | (req_wdata & bm)) & LED_ALL;
                   else rd = mMask;
                5: if (!BLINK_EN || req_we) err = 1;
                   else rd = mTicks;
                default: err = 1;
            endcase
            mRdata = rd;
            mErr   = err;
            mValid = 1;
            mReady = 0;
        end else if (mValid) begin
            if (rsp_ready) begin
                mValid    = 0;
                mReady    = 1;
                mConsumed = 1;
            end
        end else begin
            mReady = 1;
        end
        if (tickNow) begin
            newLed = newLed ^ mMask;
            mTicks = mTicks + 1;
        end
        if (divWritten || tickNow) mPresc = 0;
        else mPresc = mPresc + 1;
        mLedOut = newLed;
        mMask   = newMask;
        mDiv    = newDiv;
    endfunction

    // One clock: update the model at the edge, compare shortly after, return at the falling edge.
    task automatic cycle();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("req_ready", 32'(req_ready), 32'(mReady));
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(mValid));
        checkOutput("led", 32'(led), 32'(mLed));
        if (mValid || mInReset) begin
            checkOutput("rsp_rdata", rsp_rdata, mRdata);
            checkOutput("rsp_err", 32'(rsp_err), 32'(mErr));
        end
        @(negedge clk);
    endtask

    // Run one bus transaction; hold delays the response consume, keepValid
    // presents a competing store while the response is pending.
    task automatic applyStimulus(input bit we, input logic [4:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input int hold, input bit keepValid,
                                 output logic [31:0] gotRdata, output logic gotErr);
        int n;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!mAccepted && n < 20);
        gotRdata = rsp_rdata;
        gotErr   = rsp_err;
        if (keepValid) begin
            req_we    = 1'b1;
            req_addr  = 5'h00;
            req_wdata = $urandom;
            req_wstrb = 4'hF;
        end else begin
            req_valid = 1'b0;
        end
        for (int i = 0; i < hold; i++) cycle();
        rsp_ready = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!mConsumed && n < 20);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic doReset(input int len);
        reset = 1'b1;
        for (int i = 0; i < len; i++) cycle();
        reset = 1'b0;
        cycle();
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          toggles;
        logic        prevLed;
        logic [4:0]  a;
        logic [31:0] d;

        reset = 1'b1; req_valid = 0; req_we = 0; req_addr = 0;
        req_wdata = 0; req_wstrb = 0; rsp_ready = 0;

        // reset for two cycles, then ready appears
        doReset(2);
        checkOutput("ready_after_reset", 32'(req_ready), 32'd1);

        // LED_OUT store and load back
        applyStimulus(1, 5'h00, 32'h0000_00A5, 4'hF, 0, 0, rd, er);
        applyStimulus(0, 5'h00, 32'h0, 4'h0, 0, 0, rd, er);
        checkOutput("load_led_out", rd, 32'h0000_00A5);
        checkOutput("load_led_out_err", 32'(er), 32'd0);
        checkOutput("led_a5", 32'(led), 32'h0000_00A5);

        // SET / CLR, and reads of write-only registers
        applyStimulus(1, 5'h00, 32'h0000_00F0, 4'hF, 0, 0, rd, er);
        applyStimulus(1, 5'h04, 32'h0000_000F, 4'hF, 1, 0, rd, er);
        applyStimulus(1, 5'h08, 32'h0000_0081, 4'hF, 0, 0, rd, er);
        applyStimulus(0, 5'h04, 32'h0, 4'h0, 0, 0, rd, er);
        checkOutput("load_led_set", rd, 32'h0);
        checkOutput("led_7e", 32'(led), 32'h0000_007E);

        // byte strobes: lane 1 only must leave LED_OUT alone, wstrb=0 is a no-op
        applyStimulus(1, 5'h00, 32'h0000_FF00, 4'h2, 0, 0, rd, er);
        applyStimulus(1, 5'h04, 32'h0000_00FF, 4'h0, 0, 0, rd, er);
        checkOutput("wstrb0_err", 32'(er), 32'd0);
        applyStimulus(0, 5'h03, 32'h0, 4'h0, 0, 0, rd, er);
        checkOutput("strobe_led_out", rd, 32'h0000_007E);

        // unmapped load and store to TICKS
        applyStimulus(0, 5'h18, 32'h0, 4'h0, 0, 0, rd, er);
        checkOutput("unmapped_err", 32'(er), 32'd1);
        checkOutput("unmapped_rdata", rd, 32'h0);
        applyStimulus(1, 5'h14, 32'hDEAD_BEEF, 4'hF, 0, 0, rd, er);
        checkOutput("ticks_store_err", 32'(er), 32'd1);

        // response held for five cycles with a competing request
        applyStimulus(0, 5'h00, 32'h0, 4'h0, 5, 1, rd, er);
        checkOutput("held_load", rd, 32'h0000_007E);
        checkOutput("led_not_overwritten", 32'(led), 32'h0000_007E);

        // reset arriving while a response is pending
        req_we = 0; req_addr = 5'h00; req_wstrb = 0; req_valid = 1;
        cycle();
        req_valid = 0;
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        cycle();
        cycle();
        checkOutput("led_after_midreset", 32'(led), 32'h0);

`ifdef MMIO_LED_BLINK_EN
        // blink: divider 4, mask on LED 0
        doReset(2);
        applyStimulus(1, 5'h0C, 32'd4, 4'hF, 0, 0, rd, er);
        applyStimulus(1, 5'h10, 32'h1, 4'hF, 0, 0, rd, er);
        toggles = 0;
        prevLed = led[0];
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (led[0] !== prevLed) toggles++;
            prevLed = led[0];
        end
        checkOutput("blink_toggles", toggles, 32'd3);
        applyStimulus(0, 5'h14, 32'h0, 4'h0, 0, 0, rd, er);
        applyStimulus(0, 5'h0C, 32'h0, 4'h0, 0, 0, rd, er);
        checkOutput("blink_div_read", rd, 32'd4);
`endif

        // random traffic against the model
        for (int t = 0; t < 300; t++) begin
            a = 5'($urandom);
            d = $urandom;
            if (a[4:2] == 3'd3) d = $urandom_range(0, 6);
            applyStimulus($urandom_range(0, 1), a, d,
                          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                          $urandom_range(0, 3), $urandom_range(0, 1), rd, er);
            for (int g = $urandom_range(0, 2); g > 0; g--) cycle();
            if ($urandom_range(0, 59) == 0) doReset(1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
